fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the 5-stage MIPS pipeline. It replaces the purely combinational EX-stage bypass mux. It adds:
- a load-use stall state machine with a configurable load latency;
- a shift-register history of retired writebacks, so forwarding stays correct after multi-cycle stalls when the register file is not write-through;
- a saturating stall-cycle counter.

It sits beside ID/EX. It drives the EX operand muxes and the PC/IF-ID hold and ID/EX bubble controls.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; register 0 is never forwarded
- HIST_DEPTH, 2, retired-write history entries (1..4); used only with FWD_HIST_EN
- LOAD_LAT, 1, stall cycles per load-use hazard (1..3)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset: synchronous, active-high, sampled on the rising edge of clk
- id_rs, id_rt  in  REG_AW  sources of the instruction in ID
- ex_rs, ex_rt  in  REG_AW  sources of the instruction in EX
- ex_rs_data, ex_rt_data  in  DATA_W  register-file values latched in ID/EX
- ex_rd  in  REG_AW  EX destination
- ex_rw  in  1  EX writes a register
- ex_is_load  in  1  EX instruction is a load
- mem_rd  in  REG_AW  MEM destination
- mem_rw  in  1  MEM writes a register
- mem_result  in  DATA_W  MEM ALU result
- wb_rd  in  REG_AW  WB destination
- wb_rw  in  1  WB writes a register
- wb_to_reg  in  1  1 = select wb_read_data, 0 = select wb_result
- wb_read_data, wb_result  in  DATA_W  WB candidates
- fwd_rs_data, fwd_rt_data  out  DATA_W  forwarded EX operands
- fwd_rs_sel, fwd_rt_sel  out  2  source: 0 = regfile, 1 = MEM, 2 = WB, 3 = history
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load a NOP into ID/EX
- stall_cycles  out  16  saturating count of cycles with stall=1

## Operation
- Define wb_data = wb_to_reg ? wb_read_data : wb_result.
- Operand select per source s (rs, rt), combinational. Priority order:
  - MEM, when mem_rw, mem_rd==s and mem_rd!=0.
  - WB, when wb_rw, wb_rd==s and wb_rd!=0.
  - History: the newest valid entry with rd==s.
  - Otherwise the regfile value.
- s==0 always selects the regfile.
- History buffer:
  - Each clock with wb_rw=1 and wb_rd!=0 shifts in {valid=1, wb_rd, wb_data} at entry 0.
  - Older entries move up; entry HIST_DEPTH-1 is dropped.
  - Duplicate rd values are allowed; the lowest index wins.
  - If no write occurs, the buffer holds.
- Load-use detection (det): ex_is_load & ex_rw & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
- FSM states: IDLE and STALL, with a 2-bit counter cnt.
  - IDLE: stall = bubble = det.
  - IDLE with det and LOAD_LAT>1: go to STALL with cnt = LOAD_LAT-1.
  - IDLE with det and LOAD_LAT==1: stay in IDLE.
  - STALL: stall = bubble = 1; cnt decrements each cycle; when cnt==1 the next state is IDLE.
  - det is ignored in STALL, because ID/EX holds a bubble.
- stall_cycles increments each cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- Forward data, sel, stall and bubble are combinational, with zero-cycle latency from their inputs.
- The history entry written at edge N is visible for forwarding in cycle N+1.
- A load-use hazard produces exactly LOAD_LAT consecutive cycles with stall=bubble=1, starting in the cycle det is first high.
- A WB write in the same cycle as a hazard is captured normally; the history never stalls.
- Reset:
  - State IDLE, cnt=0, all history valid bits 0, stall_cycles=0.
  - While rst=1, stall=0 and bubble=0 (forced).
  - Forward outputs follow the mux, with no history hits.
- Reset during STALL: the unit returns to IDLE at that edge and the remaining stall cycles are abandoned.

## Configuration
- FWD_HIST_EN defined: the history buffer is built, and sel=3 is reachable.
- FWD_HIST_EN undefined: no history storage; HIST_DEPTH is ignored; sel is only ever 0, 1 or 2. Loads with LOAD_LAT>1 then require a write-through register file.

## Test plan
- MEM/WB priority: ex_rs=3, mem_rd=3/mem_rw=1/mem_result=0xAAAA0000, wb_rd=3/wb_rw=1 -> fwd_rs_data=0xAAAA0000, fwd_rs_sel=1. Then ex_rs=0 with mem_rd=0 -> sel=0, regfile data.
- wb_to_reg: wb_rd=7, wb_to_reg=1, wb_read_data=0x1234, ex_rt=7 -> fwd_rt_data=0x1234, sel=2.
- Load-use, LOAD_LAT=3: ex_is_load=1, ex_rd=5, id_rt=5 -> stall=bubble=1 for exactly 3 cycles, then 0; stall_cycles=3.
- History (FWD_HIST_EN, HIST_DEPTH=2): WB writes r9=0x11, then r9=0x22, then idle; ex_rs=9 with no MEM/WB match -> 0x22, sel=3. After two further writes to r1 and r2 -> sel=0.
- Reset mid-stall: rst=1 in the 2nd stall cycle -> stall=0 on the next cycle, history misses, stall_cycles=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, retired-write history and load-use stall control.
// Define FWD_HIST_EN to build the retired-write history buffer (sel=3 source).
module fwd_hazard_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned HIST_DEPTH = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [DATA_W-1:0] ex_rs_data,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rw,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rw,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rw,
  input  logic              wb_to_reg,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              stall,
  output logic              bubble,
  output logic [15:0]       stall_cycles
);

  typedef enum logic {IDLE, STALL} hazState_e;

  if (LOAD_LAT < 1 || LOAD_LAT > 3 || HIST_DEPTH < 1 || HIST_DEPTH > 4) begin : gBadParam
    $error("fwd_hazard_unit: LOAD_LAT must be 1..3 and HIST_DEPTH 1..4");
  end

  logic [DATA_W-1:0] wbData;
  assign wbData = wb_to_reg ? wb_read_data : wb_result;

`ifdef FWD_HIST_EN
  logic              histValid [HIST_DEPTH];
  logic [REG_AW-1:0] histRd    [HIST_DEPTH];
  logic [DATA_W-1:0] histData  [HIST_DEPTH];

  // Newest retired write enters at entry 0; the oldest falls off the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(HIST_DEPTH); i++) histValid[i] <= 1'b0;
    end else if (wb_rw && wb_rd != '0) begin
      histValid[0] <= 1'b1;
      histRd[0]    <= wb_rd;
      histData[0]  <= wbData;
      for (int i = 1; i < int'(HIST_DEPTH); i++) begin
        histValid[i] <= histValid[i-1];
        histRd[i]    <= histRd[i-1];
        histData[i]  <= histData[i-1];
      end
    end
  end
`endif

  // Returns {sel, data}: MEM beats WB beats history beats regfile.
  function automatic logic [DATA_W+1:0] fwdPick(input logic [REG_AW-1:0] src,
                                                input logic [DATA_W-1:0] rfData);
    logic [DATA_W+1:0] r;
    r = {2'd0, rfData};
    if (src != '0) begin
      if (mem_rw && mem_rd == src) begin
        r = {2'd1, mem_result};
      end else if (wb_rw && wb_rd == src) begin
        r = {2'd2, wbData};
      end
`ifdef FWD_HIST_EN
      else if (!rst) begin
        // Scan oldest to newest so the lowest matching index wins.
        for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
          if (histValid[i] && histRd[i] == src) r = {2'd3, histData[i]};
        end
      end
`endif
    end
    return r;
  endfunction

  assign {fwd_rs_sel, fwd_rs_data} = fwdPick(ex_rs, ex_rs_data);
  assign {fwd_rt_sel, fwd_rt_data} = fwdPick(ex_rt, ex_rt_data);

  hazState_e  state;
  logic [1:0] cnt;
  logic       det;

  assign det    = ex_is_load && ex_rw && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign stall  = !rst && ((state == STALL) || det);
  assign bubble = stall;

  // First stall cycle comes from det in IDLE; STALL covers the remaining LOAD_LAT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      case (state)
        IDLE: begin
          if (det && LOAD_LAT > 1) begin
            state <= STALL;
            cnt   <= 2'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (LOAD_LAT=3, HIST_DEPTH=2).
// Expectations follow FWD_HIST_EN so the bench suits both builds.
module tb_fwd_hazard_unit;

`ifdef FWD_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic [31:0] ex_rs_data, ex_rt_data, mem_result, wb_read_data, wb_result;
  logic        ex_rw, ex_is_load, mem_rw, wb_rw, wb_to_reg;
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic        stall, bubble;
  logic [15:0] stall_cycles;

  fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .HIST_DEPTH(2), .LOAD_LAT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_rw(mem_rw), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_rw(wb_rw), .wb_to_reg(wb_to_reg),
    .wb_read_data(wb_read_data), .wb_result(wb_result),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall(stall), .bubble(bubble), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
    logic [31:0] exRsData, exRtData, memResult, wbReadData, wbResult;
    logic        exRw, exIsLoad, memRw, wbRw, wbToReg;
  } inT;

  typedef struct {
    string       name;
    logic [1:0]  rsSel, rtSel;
    logic [31:0] rsData, rtData;
    logic        stl;
    logic [15:0] cyc;
  } expT;

  typedef struct { inT in; expT exp; } vecT;

  expT sb[$];
  int  tests = 0;
  int  failed = 0;

  function automatic inT zeroIn();
    inT v;
    v.idRs = '0; v.idRt = '0; v.exRs = '0; v.exRt = '0; v.exRd = '0;
    v.memRd = '0; v.wbRd = '0;
    v.exRsData = '0; v.exRtData = '0; v.memResult = '0;
    v.wbReadData = '0; v.wbResult = '0;
    v.exRw = 1'b0; v.exIsLoad = 1'b0; v.memRw = 1'b0; v.wbRw = 1'b0; v.wbToReg = 1'b0;
    return v;
  endfunction

  function automatic expT mkExp(input string n, input logic [1:0] rss, input logic [31:0] rsd,
                                input logic [1:0] rts, input logic [31:0] rtd,
                                input logic s, input logic [15:0] c);
    expT e;
    e.name = n; e.rsSel = rss; e.rsData = rsd; e.rtSel = rts; e.rtData = rtd;
    e.stl = s; e.cyc = c;
    return e;
  endfunction

  task automatic apply(input inT v);
    id_rs = v.idRs; id_rt = v.idRt; ex_rs = v.exRs; ex_rt = v.exRt;
    ex_rs_data = v.exRsData; ex_rt_data = v.exRtData;
    ex_rd = v.exRd; ex_rw = v.exRw; ex_is_load = v.exIsLoad;
    mem_rd = v.memRd; mem_rw = v.memRw; mem_result = v.memResult;
    wb_rd = v.wbRd; wb_rw = v.wbRw; wb_to_reg = v.wbToReg;
    wb_read_data = v.wbReadData; wb_result = v.wbResult;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic checkFront();
    expT e;
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".rs"}, 64'({fwd_rs_sel, fwd_rs_data}), 64'({e.rsSel, e.rsData}));
      chk({e.name, ".rt"}, 64'({fwd_rt_sel, fwd_rt_data}), 64'({e.rtSel, e.rtData}));
      chk({e.name, ".stall"}, 64'({stall, bubble}), 64'({e.stl, e.stl}));
      chk({e.name, ".cycles"}, 64'(stall_cycles), 64'(e.cyc));
    end
  endtask

  // Drive after the rising edge, compare on the falling edge.
  task automatic cycle(input inT v, input logic r, input expT e);
    @(posedge clk);
    #1;
    apply(v);
    rst = r;
    sb.push_back(e);
    @(negedge clk);
    checkFront();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  vecT tbl[8];
  inT  v;

  initial begin
    apply(zeroIn());

    // Reset holds stall/bubble low even with a live hazard.
    v = zeroIn(); v.exIsLoad = 1; v.exRw = 1; v.exRd = 5; v.idRt = 5;
    cycle(v, 1'b1, mkExp("reset", 2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 16'd0));

    v = zeroIn(); v.exRs = 3; v.exRt = 20; v.exRsData = 32'h1111; v.exRtData = 32'h2020;
    v.memRd = 3; v.memRw = 1; v.memResult = 32'hAAAA0000; v.wbRd = 3; v.wbRw = 1; v.wbResult = 32'hBBBB;
    tbl[0].in = v; tbl[0].exp = mkExp("mem_wb_pri", 2'd1, 32'hAAAA0000, 2'd0, 32'h2020, 1'b0, 16'd0);
    v = zeroIn(); v.exRs = 0; v.exRsData = 32'h5555; v.exRt = 21; v.exRtData = 32'h21;
    v.memRd = 0; v.memRw = 1; v.memResult = 32'hDEAD; v.wbRd = 0; v.wbRw = 1; v.wbResult = 32'hBEEF;
    tbl[1].in = v; tbl[1].exp = mkExp("zero_src", 2'd0, 32'h5555, 2'd0, 32'h21, 1'b0, 16'd0);
    v = zeroIn(); v.exRt = 7; v.exRs = 22; v.exRsData = 32'h22; v.memRd = 7;
    v.wbRd = 7; v.wbRw = 1; v.wbToReg = 1; v.wbReadData = 32'h1234; v.wbResult = 32'h9999;
    tbl[2].in = v; tbl[2].exp = mkExp("wb_to_reg", 2'd0, 32'h22, 2'd2, 32'h1234, 1'b0, 16'd0);
    v = zeroIn(); v.exRs = 8; v.exRt = 8; v.exRtData = 32'h88; v.memRd = 8;
    v.wbRd = 8; v.wbRw = 1; v.wbReadData = 32'hF00D; v.wbResult = 32'hCAFE;
    tbl[3].in = v; tbl[3].exp = mkExp("wb_result", 2'd2, 32'hCAFE, 2'd2, 32'hCAFE, 1'b0, 16'd0);
    v = zeroIn(); v.exRt = 9; v.exRs = 23; v.exRsData = 32'h23;
    v.memRd = 9; v.memRw = 1; v.memResult = 32'h77; v.wbRd = 9;
    tbl[4].in = v; tbl[4].exp = mkExp("mem_only", 2'd0, 32'h23, 2'd1, 32'h77, 1'b0, 16'd0);
    v = zeroIn(); v.exRs = 10; v.exRt = 10; v.exRsData = 32'h10; v.exRtData = 32'h1010;
    v.memRd = 10; v.wbRd = 10; v.memResult = 32'h1; v.wbResult = 32'h2;
    tbl[5].in = v; tbl[5].exp = mkExp("rw_off", 2'd0, 32'h10, 2'd0, 32'h1010, 1'b0, 16'd0);
    v = zeroIn(); v.exRs = 11; v.exRt = 12; v.memRd = 11; v.memRw = 1; v.memResult = 32'h1100;
    v.wbRd = 12; v.wbRw = 1; v.wbToReg = 1; v.wbReadData = 32'h1200;
    tbl[6].in = v; tbl[6].exp = mkExp("split", 2'd1, 32'h1100, 2'd2, 32'h1200, 1'b0, 16'd0);
    v = zeroIn(); v.exRs = 31; v.exRsData = 32'hFFFFFFFF;
    tbl[7].in = v; tbl[7].exp = mkExp("all_ones", 2'd0, 32'hFFFFFFFF, 2'd0, 32'h0, 1'b0, 16'd0);

    foreach (tbl[i]) cycle(tbl[i].in, 1'b0, tbl[i].exp);

    // Load-use with LOAD_LAT=3; a WB write in the hazard cycle lands in history.
    cycle(zeroIn(), 1'b1, mkExp("lu_rst", 2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 16'd0));
    v = zeroIn(); v.exIsLoad = 1; v.exRw = 1; v.exRd = 5; v.idRt = 5;
    v.wbRd = 13; v.wbRw = 1; v.wbResult = 32'h1313;
    cycle(v, 1'b0, mkExp("lu1", 2'd0, 32'h0, 2'd0, 32'h0, 1'b1, 16'd0));
    v.wbRw = 0; v.exRs = 13; v.exRsData = 32'h1D;
    cycle(v, 1'b0, mkExp("lu2", HIST ? 2'd3 : 2'd0, HIST ? 32'h1313 : 32'h1D,
                         2'd0, 32'h0, 1'b1, 16'd1));
    cycle(v, 1'b0, mkExp("lu3", HIST ? 2'd3 : 2'd0, HIST ? 32'h1313 : 32'h1D,
                         2'd0, 32'h0, 1'b1, 16'd2));
    v.exIsLoad = 0;
    cycle(v, 1'b0, mkExp("lu4", HIST ? 2'd3 : 2'd0, HIST ? 32'h1313 : 32'h1D,
                         2'd0, 32'h0, 1'b0, 16'd3));
    cycle(v, 1'b0, mkExp("lu5", HIST ? 2'd3 : 2'd0, HIST ? 32'h1313 : 32'h1D,
                         2'd0, 32'h0, 1'b0, 16'd3));

    // History depth 2: newest r9 wins, then ages out after two more writes.
    cycle(zeroIn(), 1'b1, mkExp("h_rst", 2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 16'd3));
    v = zeroIn(); v.wbRd = 9; v.wbRw = 1; v.wbResult = 32'h11;
    cycle(v, 1'b0, mkExp("h_w1", 2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 16'd0));
    v.wbResult = 32'h22;
    cycle(v, 1'b0, mkExp("h_w2", 2'd0, 32'h0, 2'd0, 32'h0, 1'b0, 16'd0));
    v = zeroIn(); v.exRs = 9; v.exRt = 9; v.exRsData = 32'h99; v.exRtData = 32'h98;
    cycle(v, 1'b0, mkExp("h_hit", HIST ? 2'd3 : 2'd0, HIST ? 32'h22 : 32'h99,
                         HIST ? 2'd3 : 2'd0, HIST ? 32'h22 : 32'h98, 1'b0, 16'd0));
    v.wbRd = 1; v.wbRw = 1; v.wbResult = 32'h1;
    cycle(v, 1'b0, mkExp("h_w3", HIST ? 2'd3 : 2'd0, HIST ? 32'h22 : 32'h99,
                         HIST ? 2'd3 : 2'd0, HIST ? 32'h22 : 32'h98, 1'b0, 16'd0));
    v.wbRd = 2; v.wbResult = 32'h2;
    cycle(v, 1'b0, mkExp("h_w4", HIST ? 2'd3 : 2'd0, HIST ? 32'h22 : 32'h99,
                         HIST ? 2'd3 : 2'd0, HIST ? 32'h22 : 32'h98, 1'b0, 16'd0));
    v = zeroIn(); v.exRs = 9; v.exRsData = 32'h99; v.exRt = 1; v.exRtData = 32'h77;
    cycle(v, 1'b0, mkExp("h_aged", 2'd0, 32'h99, HIST ? 2'd3 : 2'd0, HIST ? 32'h1 : 32'h77,
                         1'b0, 16'd0));

    // Reset in the second stall cycle abandons the stall and clears history.
    v = zeroIn(); v.exIsLoad = 1; v.exRw = 1; v.exRd = 5; v.idRs = 5;
    v.exRs = 2; v.exRsData = 32'h202;
    cycle(v, 1'b0, mkExp("rs_st1", HIST ? 2'd3 : 2'd0, HIST ? 32'h2 : 32'h202,
                         2'd0, 32'h0, 1'b1, 16'd0));
    cycle(v, 1'b1, mkExp("rs_rst", 2'd0, 32'h202, 2'd0, 32'h0, 1'b0, 16'd1));
    v.exIsLoad = 0;
    cycle(v, 1'b0, mkExp("rs_after", 2'd0, 32'h202, 2'd0, 32'h0, 1'b0, 16'd0));
    cycle(v, 1'b0, mkExp("rs_idle", 2'd0, 32'h202, 2'd0, 32'h0, 1'b0, 16'd0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
